// File: rtl/mips_seq_ctrl_pkg.sv
// Shared opcode/funct constants, ALU encodings, FSM states and the decoded
// control bundle for the MIPS-subset sequencer.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, WB, HALT
  } state_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  wr_addr;
    logic        alu_op;
    logic        alu_src_imm;
    logic [15:0] imm;
    logic        legal;
  } ctrl_t;

endpackage

// File: rtl/mips_seq_ctrl_if.sv
// Instruction-memory and datapath control bus between the sequencer
// (master) and the imem/regfile/ALU side (slave).
interface mips_seq_ctrl_if #(parameter int PC_W = 3);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [4:0]      rf_rd_addr1;
  logic [4:0]      rf_rd_addr2;
  logic [4:0]      rf_wr_addr;
  logic            rf_wr_en;
  logic            alu_op;
  logic            alu_src_imm;
  logic [15:0]     imm;

  modport master (
    output imem_addr, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_wr_en,
           alu_op, alu_src_imm, imm,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr, rf_rd_addr1, rf_rd_addr2, rf_wr_addr, rf_wr_en,
           alu_op, alu_src_imm, imm,
    output imem_rdata
  );
endinterface

// File: rtl/mips_seq_ctrl_decoder.sv
// Combinational decode of one instruction word into datapath controls.
// Unsupported encodings come out with legal=0 and a zero write address.
module mips_decoder
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl
);

  // Field extraction plus per-opcode control selection
  always_comb begin
    ctrl             = '0;
    ctrl.rs          = instr[25:21];
    ctrl.rt          = instr[20:16];
    ctrl.imm         = instr[15:0];
    if (instr[31:26] == OP_RTYPE && instr[5:0] == FN_ADDU) begin
      ctrl.wr_addr = instr[15:11];
      ctrl.alu_op  = ALU_ADD;
      ctrl.legal   = 1'b1;
    end else if (instr[31:26] == OP_RTYPE && instr[5:0] == FN_SUBU) begin
      ctrl.wr_addr = instr[15:11];
      ctrl.alu_op  = ALU_SUB;
      ctrl.legal   = 1'b1;
    end else if (instr[31:26] == OP_ADDIU) begin
      ctrl.wr_addr     = instr[20:16];
      ctrl.alu_op      = ALU_ADD;
      ctrl.alu_src_imm = 1'b1;
      ctrl.legal       = 1'b1;
    end
  end

endmodule

// File: rtl/mips_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer for the MIPS-subset datapath.
// Controls are decoded from the instruction register, so they hold from
// EXEC through WB. Optional trace output under MIPS_SEQ_TRACE_EN.
module mips_seq_ctrl
  import mips_pkg::*;
#(
  parameter int PROG_LEN = 7,
  parameter int PC_W     = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  mips_seq_ctrl_if.master     bus,
  output logic [PC_W-1:0]     pc,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [PC_W:0]       instr_cnt
);

  localparam logic [PC_W-1:0] PC_LAST = PC_W'(PROG_LEN - 1);

  state_t      state, state_nxt;
  logic [31:0] ir;
  logic        illegal_q;
  logic        last;
  ctrl_t       dec;

  assign last = (pc == PC_LAST);

  mips_decoder u_dec (
    .instr (ir),
    .ctrl  (dec)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic: fixed 4-cycle instruction loop, start only when idle
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT: if (start) state_nxt = FETCH;
      FETCH:      state_nxt = DECODE;
      DECODE:     state_nxt = EXEC;
      EXEC:       state_nxt = WB;
      WB:         state_nxt = last ? HALT : FETCH;
      default:    state_nxt = IDLE;
    endcase
  end

  // pc, retire counter, instruction register and sticky illegal flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= '0;
      instr_cnt <= '0;
      ir        <= '0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        IDLE, HALT: if (start) begin
          pc        <= '0;
          instr_cnt <= '0;
          illegal_q <= 1'b0;
        end
        DECODE: ir <= bus.imem_rdata;
        WB: begin
          pc        <= last ? '0 : pc + PC_W'(1);
          instr_cnt <= instr_cnt + (PC_W+1)'(1);
          illegal_q <= illegal;
        end
        default: ;
      endcase
    end
  end

  // The current instruction's illegal bit shows as soon as it sits in ir
  // (EXEC onward); it is folded into the sticky flag at WB exit.
  assign illegal = illegal_q | ((state == EXEC || state == WB) && !dec.legal);

  assign busy = (state == FETCH) || (state == DECODE) ||
                (state == EXEC)  || (state == WB);
  assign done = (state == HALT);

  assign bus.imem_addr   = pc;
  assign bus.rf_rd_addr1 = dec.rs;
  assign bus.rf_rd_addr2 = dec.rt;
  assign bus.rf_wr_addr  = dec.wr_addr;
  assign bus.alu_op      = dec.alu_op;
  assign bus.alu_src_imm = dec.alu_src_imm;
  assign bus.imm         = dec.imm;
  // Writes to $zero and illegal instructions never strobe the regfile
  assign bus.rf_wr_en    = (state == WB) && dec.legal && (dec.wr_addr != 5'd0);

`ifdef MIPS_SEQ_TRACE_EN
  // Simulation trace of each writeback and each unsupported decode
  always @(posedge clk) begin
    if (rst_n && state == WB)
      $display("pc=%d instr=%h wr=%d/%b", pc, ir, dec.wr_addr, bus.rf_wr_en);
    if (rst_n && state == EXEC && !dec.legal)
      $display("ILLEGAL pc=%d", pc);
  end
`endif

endmodule
